if_axi_read_bridge: RTL and testbench
=====================================

# if_axi_read_bridge

Instruction-fetch responder on the IF side, AXI4 read initiator on the memory side. Accepts the fetch stage's `if_valid`/`if_addr` request, issues one single-beat AXI4 read of the aligned 64-bit word, and returns the selected 32-bit instruction with a one-cycle `if_read_isdone` pulse. Requests abandoned by a flush are drained from AXI and discarded. One read outstanding at a time.

## Interface
Parameters:
- `ADDR_W`, 64: fetch/AXI address width
- `DATA_W`, 64: AXI data width; also the `if_data_read` width
- `AXI_ID`, 4'd0: constant `axi_ar_id`

Ports:
- `cpu_clk_50M`  in  1  single clock
- `cpu_rst`  in  1  reset, asynchronous, active-high
- `if_valid`  in  1  fetch request; held with `if_addr` until done, dropped or changed on flush
- `if_addr`  in  ADDR_W  fetch PC, 4-byte aligned
- `if_data_read`  out  DATA_W  instruction in [31:0], upper bits zero
- `if_read_isdone`  out  1  one-cycle completion pulse
- `if_fetch_err`  out  1  qualifies `if_read_isdone`; AXI error response
- `if_axi_busy`  out  1  state != IDLE
- `axi_ar_valid`  out  1
- `axi_ar_ready`  in  1
- `axi_ar_addr`  out  ADDR_W  `req_addr` with [2:0] = 0
- `axi_ar_id`  out  4  = AXI_ID
- `axi_ar_len`  out  8  = 0
- `axi_ar_size`  out  3  = 3'b011
- `axi_ar_burst`  out  2  = 2'b01 (INCR)
- `axi_ar_prot`  out  3  = 3'b100 (instruction)
- `axi_ar_cache`  out  4  = 4'b0010
- `axi_r_valid`  in  1
- `axi_r_ready`  out  1
- `axi_r_data`  in  DATA_W
- `axi_r_resp`  in  2
- `axi_r_last`  in  1  ignored (len 0)

## Operation
- States: IDLE, AR, R, DONE.
- IDLE: when `if_valid`=1, latch `req_addr` = `if_addr` and go to AR.
- AR: `axi_ar_valid`=1. Address is held stable until `axi_ar_ready`; on handshake go to R. A flush does not withdraw AR (AXI rule).
- R: `axi_r_ready`=1. On `axi_r_valid`, capture data into `rdata_q`: `req_addr[2]`=0 selects r_data[31:0], 1 selects r_data[63:32]. Zero-extend to DATA_W. Capture `err_q` = (`r_resp` != 2'b00). Go to DONE.
- DONE, one cycle only: `if_read_isdone` = `if_valid` && (`if_addr` == `req_addr`). It is combinational from the current inputs, so a flush or redirect during this cycle suppresses the pulse. Next state is IDLE unconditionally.
- `if_data_read` = `rdata_q` and `if_fetch_err` = `err_q` while `if_read_isdone`=1; otherwise 0. On error, `rdata_q` is forced to 0.
- Stale requests: a response whose address no longer matches is discarded silently. A new request is issued from IDLE on the following cycle.

## Timing
- Reset (async assert): state = IDLE; `req_addr`, `rdata_q`, `err_q` = 0; every output 0 except the AXI constant fields.
- Reset mid-transaction abandons it. The AXI slave must also be reset.
- Zero-wait latency: `if_valid` seen in cycle 0, `axi_ar_valid` in cycle 1, `r_valid` in cycle 2, `if_read_isdone` in cycle 3. Next request is accepted in cycle 4 (IDLE), AR in cycle 5. Throughput is one fetch per 4 cycles.
- Each extra `ar_ready` or `r_valid` wait cycle adds one cycle.
- `axi_ar_valid` and `axi_r_ready` are registered from the state; there is no combinational path from AXI inputs to AXI outputs.
- `if_read_isdone` never asserts outside DONE and is never high for 2 consecutive cycles.

## Test plan
- Reset then `if_valid`=1, `if_addr`=0x8000_0000, zero-wait slave returning r_data=0x1111_2222_3333_4444 → AR addr 0x8000_0000 in cycle 1; done pulse in cycle 3 with `if_data_read`=0x3333_4444 and `if_fetch_err`=0.
- `if_addr`=0x8000_0004, same data → `axi_ar_addr`=0x8000_0000, `if_data_read`=0x1111_2222.
- `ar_ready` delayed 3 cycles and `r_valid` delayed 2 → `axi_ar_addr` stable throughout AR; done in cycle 8; `if_axi_busy`=1 cycles 1-8.
- Flush: `if_addr` changes 0x8000_0000→0x8000_0100 while in R → no done pulse; return to IDLE; new AR for 0x8000_0100 follows; done with the new data.
- `r_resp`=2'b10 → done with `if_fetch_err`=1 and `if_data_read`=0.
- Async `cpu_rst` pulse while in AR → all outputs 0 immediately; after release, a fresh request completes normally.

Source files
------------

// File: rtl/if_axi_read_bridge.sv
// rtl/if_axi_read_bridge.sv - instruction-fetch to AXI4 single-beat read bridge
// One read outstanding; responses for flushed/redirected fetches are drained and dropped.
module if_axi_read_bridge #(
  parameter int           ADDR_W = 64,
  parameter int           DATA_W = 64,
  parameter logic [3:0]   AXI_ID = 4'd0
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_data_read,
  output logic              if_read_isdone,
  output logic              if_fetch_err,
  output logic              if_axi_busy,
  output logic              axi_ar_valid,
  input  logic              axi_ar_ready,
  output logic [ADDR_W-1:0] axi_ar_addr,
  output logic [3:0]        axi_ar_id,
  output logic [7:0]        axi_ar_len,
  output logic [2:0]        axi_ar_size,
  output logic [1:0]        axi_ar_burst,
  output logic [2:0]        axi_ar_prot,
  output logic [3:0]        axi_ar_cache,
  input  logic              axi_r_valid,
  output logic              axi_r_ready,
  input  logic [DATA_W-1:0] axi_r_data,
  input  logic [1:0]        axi_r_resp,
  input  logic              axi_r_last
);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_req_addr;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic [31:0]         w_word;
  logic                w_resp_err;

  assign w_word     = r_req_addr[2] ? axi_r_data[63:32] : axi_r_data[31:0];
  // r_last carries no information for a single-beat burst; folded in as a no-op.
  assign w_resp_err = (axi_r_resp != 2'b00) | (axi_r_last & 1'b0);

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_state    <= S_IDLE;
      r_req_addr <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && if_valid)
        r_req_addr <= if_addr;
      if (r_state == S_R && axi_r_valid) begin
        r_err   <= w_resp_err;
        r_rdata <= w_resp_err ? '0 : DATA_W'(w_word);
      end
    end
  end

  always_comb begin
    w_next         = r_state;
    if_read_isdone = 1'b0;
    case (r_state)
      S_IDLE: if (if_valid) w_next = S_AR;
      S_AR:   if (axi_ar_ready) w_next = S_R;
      S_R:    if (axi_r_valid) w_next = S_DONE;
      S_DONE: begin
        // Live compare against the current request so a same-cycle flush suppresses the pulse.
        if_read_isdone = if_valid && (if_addr == r_req_addr);
        w_next         = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign if_data_read = if_read_isdone ? r_rdata : '0;
  assign if_fetch_err = if_read_isdone & r_err;
  assign if_axi_busy  = (r_state != S_IDLE);

  assign axi_ar_valid = (r_state == S_AR);
  assign axi_r_ready  = (r_state == S_R);
  assign axi_ar_addr  = {r_req_addr[ADDR_W-1:3], 3'b000};
  assign axi_ar_id    = AXI_ID;
  assign axi_ar_len   = 8'd0;
  assign axi_ar_size  = 3'b011;
  assign axi_ar_burst = 2'b01;
  assign axi_ar_prot  = 3'b100;
  assign axi_ar_cache = 4'b0010;

endmodule

// File: tb/tb_if_axi_read_bridge.sv
// tb/tb_if_axi_read_bridge.sv - directed bench for if_axi_read_bridge
// Per-cycle expectation tables built from transaction timing rules, plus literal pins.
module tb_if_axi_read_bridge;
  localparam int MAXC = 512;

  logic        cpu_clk_50M = 1'b0;
  logic        cpu_rst;
  logic        if_valid;
  logic [63:0] if_addr;
  logic [63:0] if_data_read;
  logic        if_read_isdone, if_fetch_err, if_axi_busy;
  logic        axi_ar_valid, axi_ar_ready;
  logic [63:0] axi_ar_addr;
  logic [3:0]  axi_ar_id;
  logic [7:0]  axi_ar_len;
  logic [2:0]  axi_ar_size;
  logic [1:0]  axi_ar_burst;
  logic [2:0]  axi_ar_prot;
  logic [3:0]  axi_ar_cache;
  logic        axi_r_valid, axi_r_ready;
  logic [63:0] axi_r_data;
  logic [1:0]  axi_r_resp;
  logic        axi_r_last;

  if_axi_read_bridge dut (
    .cpu_clk_50M(cpu_clk_50M), .cpu_rst(cpu_rst),
    .if_valid(if_valid), .if_addr(if_addr), .if_data_read(if_data_read),
    .if_read_isdone(if_read_isdone), .if_fetch_err(if_fetch_err), .if_axi_busy(if_axi_busy),
    .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready), .axi_ar_addr(axi_ar_addr),
    .axi_ar_id(axi_ar_id), .axi_ar_len(axi_ar_len), .axi_ar_size(axi_ar_size),
    .axi_ar_burst(axi_ar_burst), .axi_ar_prot(axi_ar_prot), .axi_ar_cache(axi_ar_cache),
    .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready), .axi_r_data(axi_r_data),
    .axi_r_resp(axi_r_resp), .axi_r_last(axi_r_last)
  );

  initial forever #5 cpu_clk_50M = ~cpu_clk_50M;

  int cyc = 0;
  initial forever begin
    @(posedge cpu_clk_50M);
    cyc = cyc + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // expectation tables, indexed by cycle
  logic        e_busy [MAXC];
  logic        e_arv  [MAXC];
  logic        e_rr   [MAXC];
  logic        e_done [MAXC];
  logic        e_err  [MAXC];
  logic [63:0] e_arad [MAXC];
  logic [63:0] e_data [MAXC];

  function automatic logic [63:0] pick(input logic [63:0] d, input logic [63:0] a, input logic [1:0] r);
    if (r != 2'b00) return 64'd0;
    return a[2] ? {32'd0, d[63:32]} : {32'd0, d[31:0]};
  endfunction

  // request first seen in cycle c0; AR lasts aw+1 cycles, R lasts rw+1, then one DONE cycle
  task automatic sched(input int c0, input int aw, input int rw, input logic [63:0] a,
                       input logic [63:0] d, input logic [1:0] r, input bit done);
    int last;
    last = c0 + 3 + aw + rw;
    for (int c = c0 + 1; c <= last; c++) e_busy[c] = 1'b1;
    for (int c = c0 + 1; c <= c0 + 1 + aw; c++) begin
      e_arv[c]  = 1'b1;
      e_arad[c] = a & ~64'h7;
    end
    for (int c = c0 + 2 + aw; c < last; c++) e_rr[c] = 1'b1;
    if (done) begin
      e_done[last] = 1'b1;
      e_data[last] = pick(d, a, r);
      e_err[last]  = (r != 2'b00);
    end
  endtask

  // slave: ready after s_aw wait cycles, data after s_rw wait cycles
  int          s_aw = 0, s_rw = 0;
  logic [63:0] s_data = 64'd0;
  logic [1:0]  s_resp = 2'b00;
  logic [63:0] s_addr = 64'd0;

  initial begin
    int ph, cnt;
    ph = 0; cnt = 0;
    axi_ar_ready = 1'b0; axi_r_valid = 1'b0; axi_r_data = 64'd0;
    axi_r_resp = 2'b00; axi_r_last = 1'b0;
    forever begin
      @(negedge cpu_clk_50M);
      if (cpu_rst) begin
        ph = 0; cnt = 0; axi_ar_ready = 1'b0; axi_r_valid = 1'b0; axi_r_last = 1'b0;
      end else begin
        case (ph)
          0: if (axi_ar_valid) begin
               if (cnt == s_aw) begin
                 axi_ar_ready = 1'b1; s_addr = axi_ar_addr; ph = 1; cnt = 0;
               end else cnt = cnt + 1;
             end
          1: begin
               axi_ar_ready = 1'b0;
               if (s_rw == 0) begin
                 axi_r_valid = 1'b1; axi_r_last = 1'b1; axi_r_data = s_data;
                 axi_r_resp = s_resp; ph = 3;
               end else begin
                 cnt = 1; ph = 2;
               end
             end
          2: if (cnt == s_rw) begin
               axi_r_valid = 1'b1; axi_r_last = 1'b1; axi_r_data = s_data;
               axi_r_resp = s_resp; ph = 3;
             end else cnt = cnt + 1;
          default: begin
               axi_r_valid = 1'b0; axi_r_last = 1'b0; ph = 0; cnt = 0;
             end
        endcase
      end
    end
  end

  int          last_done_cyc = -1;
  logic [63:0] last_done_data = 64'd0;
  logic        last_done_err = 1'b0;

  initial forever begin
    @(negedge cpu_clk_50M);
    if (cpu_rst) begin
      chk("rst_busy", {63'd0, if_axi_busy}, 64'd0);
      chk("rst_arvalid", {63'd0, axi_ar_valid}, 64'd0);
      chk("rst_isdone", {63'd0, if_read_isdone}, 64'd0);
    end else if (cyc < MAXC) begin
      chk("busy", {63'd0, if_axi_busy}, {63'd0, e_busy[cyc]});
      chk("ar_valid", {63'd0, axi_ar_valid}, {63'd0, e_arv[cyc]});
      if (e_arv[cyc]) chk("ar_addr", axi_ar_addr, e_arad[cyc]);
      chk("r_ready", {63'd0, axi_r_ready}, {63'd0, e_rr[cyc]});
      chk("isdone", {63'd0, if_read_isdone}, {63'd0, e_done[cyc]});
      chk("data", if_data_read, e_data[cyc]);
      chk("err", {63'd0, if_fetch_err}, {63'd0, e_err[cyc]});
      if (if_read_isdone) begin
        last_done_cyc  = cyc;
        last_done_data = if_data_read;
        last_done_err  = if_fetch_err;
      end
    end
  end

  task automatic run_txn(input logic [63:0] a, input int aw, input int rw,
                         input logic [63:0] d, input logic [1:0] r, output int c0);
    @(posedge cpu_clk_50M); #1;
    s_aw = aw; s_rw = rw; s_data = d; s_resp = r;
    if_valid = 1'b1; if_addr = a; c0 = cyc;
    sched(c0, aw, rw, a, d, r, 1'b1);
    repeat (4 + aw + rw) @(posedge cpu_clk_50M);
    #1 if_valid = 1'b0;
  endtask

  localparam logic [63:0] D1 = 64'h1111_2222_3333_4444;

  initial begin
    int c0;
    for (int i = 0; i < MAXC; i++) begin
      e_busy[i] = 0; e_arv[i] = 0; e_rr[i] = 0; e_done[i] = 0; e_err[i] = 0;
      e_arad[i] = 0; e_data[i] = 0;
    end
    cpu_rst = 1'b1; if_valid = 1'b0; if_addr = 64'd0;
    repeat (3) @(posedge cpu_clk_50M);
    #2;
    chk("rst_data", if_data_read, 64'd0);
    chk("ar_id", {60'd0, axi_ar_id}, 64'd0);
    chk("ar_len", {56'd0, axi_ar_len}, 64'd0);
    chk("ar_size", {61'd0, axi_ar_size}, 64'd3);
    chk("ar_burst", {62'd0, axi_ar_burst}, 64'd1);
    chk("ar_prot", {61'd0, axi_ar_prot}, 64'd4);
    chk("ar_cache", {60'd0, axi_ar_cache}, 64'd2);
    @(posedge cpu_clk_50M); #1 cpu_rst = 1'b0;

    run_txn(64'h8000_0000, 0, 0, D1, 2'b00, c0);
    chk("t1_done_cyc", 64'(last_done_cyc), 64'(c0 + 3));
    chk("t1_data", last_done_data, 64'h3333_4444);
    chk("t1_err", {63'd0, last_done_err}, 64'd0);
    chk("t1_slave_addr", s_addr, 64'h8000_0000);

    run_txn(64'h8000_0004, 0, 0, D1, 2'b00, c0);
    chk("t2_data", last_done_data, 64'h1111_2222);
    chk("t2_slave_addr", s_addr, 64'h8000_0000);

    run_txn(64'h8000_000C, 3, 2, 64'hDEAD_BEEF_0BAD_F00D, 2'b00, c0);
    chk("t3_done_cyc", 64'(last_done_cyc), 64'(c0 + 8));
    chk("t3_data", last_done_data, 64'hDEAD_BEEF);
    chk("t3_slave_addr", s_addr, 64'h8000_0008);

    // flush: redirect while the first read is in R
    @(posedge cpu_clk_50M); #1;
    s_aw = 0; s_rw = 1; s_data = D1; s_resp = 2'b00;
    if_valid = 1'b1; if_addr = 64'h8000_0000; c0 = cyc;
    sched(c0, 0, 1, 64'h8000_0000, D1, 2'b00, 1'b0);
    sched(c0 + 5, 0, 1, 64'h8000_0100, D1, 2'b00, 1'b1);
    repeat (2) @(posedge cpu_clk_50M);
    #1 if_addr = 64'h8000_0100;
    repeat (8) @(posedge cpu_clk_50M);
    #1 if_valid = 1'b0;
    chk("t4_done_cyc", 64'(last_done_cyc), 64'(c0 + 9));
    chk("t4_data", last_done_data, 64'h3333_4444);
    chk("t4_slave_addr", s_addr, 64'h8000_0100);

    run_txn(64'h8000_0004, 0, 0, D1, 2'b10, c0);
    chk("t5_err", {63'd0, last_done_err}, 64'd1);
    chk("t5_data", last_done_data, 64'd0);
    chk("t5_done_cyc", 64'(last_done_cyc), 64'(c0 + 3));

    // async reset while AR is waiting for ready
    @(posedge cpu_clk_50M); #1;
    s_aw = 3; s_rw = 0; s_data = D1; s_resp = 2'b00;
    if_valid = 1'b1; if_addr = 64'h8000_0020; c0 = cyc;
    e_busy[c0 + 1] = 1'b1; e_arv[c0 + 1] = 1'b1; e_arad[c0 + 1] = 64'h8000_0020;
    repeat (2) @(posedge cpu_clk_50M);
    #1 chk("t6_arvalid_pre", {63'd0, axi_ar_valid}, 64'd1);
    #1 cpu_rst = 1'b1;
    #1;
    chk("t6_arvalid_now", {63'd0, axi_ar_valid}, 64'd0);
    chk("t6_busy_now", {63'd0, if_axi_busy}, 64'd0);
    chk("t6_isdone_now", {63'd0, if_read_isdone}, 64'd0);
    if_valid = 1'b0;
    repeat (2) @(posedge cpu_clk_50M);
    #1 cpu_rst = 1'b0;

    run_txn(64'h8000_0044, 0, 0, 64'hCAFE_F00D_1234_5678, 2'b00, c0);
    chk("t7_done_cyc", 64'(last_done_cyc), 64'(c0 + 3));
    chk("t7_data", last_done_data, 64'hCAFE_F00D);

    repeat (3) @(posedge cpu_clk_50M);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
